// File: rtl/uart_word_tx.sv
// 8N1 UART serialiser for a 32-bit status word, MSB byte first, with optional CR LF trailer.
// Requests arrive either by valid/ready handshake or by detecting a change in word_in.
module uart_word_tx #(
  parameter int unsigned CLK_FREQ_HZ   = 27000000,
  parameter int unsigned BAUD          = 115200,
  parameter bit          APPEND_CRLF   = 1'b1,
  parameter bit          CHANGE_DETECT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int unsigned NBYTES       = APPEND_CRLF ? 6 : 4;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BYTE_LAST = 3'(NBYTES - 1);

  if (CLKS_PER_BIT < 2) begin : g_cfg_check
    $error("uart_word_tx: CLK_FREQ_HZ / BAUD must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [2:0]       byte_q, byte_d;
  logic [31:0]      word_q, word_d;
  logic [31:0]      last_q, last_d;
  logic             tx_q, tx_d;

  logic       req;
  logic       baud_done;
  logic [7:0] cur_byte;
  logic [2:0] bit_nxt;

  assign req        = CHANGE_DETECT ? (word_in != last_q) : word_valid;
  assign baud_done  = (baud_q == CNT_LAST);
  assign bit_nxt    = bit_q + 3'd1;
  assign word_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx         = tx_q;

  always_comb begin
    cur_byte = 8'h0A;
    case (byte_q)
      3'd0:    cur_byte = word_q[31:24];
      3'd1:    cur_byte = word_q[23:16];
      3'd2:    cur_byte = word_q[15:8];
      3'd3:    cur_byte = word_q[7:0];
      3'd4:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  // tx_d is the line level for the cycle after the edge, so tx stays purely registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    last_d  = last_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (req) begin
          state_d = START;
          tx_d    = 1'b0;
          baud_d  = '0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          word_d  = word_in;
          last_d  = word_in;
        end
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_nxt;
            tx_d  = cur_byte[bit_nxt];
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (byte_q == BYTE_LAST) begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_q + 3'd1;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      word_q  <= 32'h0;
      last_q  <= 32'h0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      last_q  <= last_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
- Serialises the core's 32-bit ASCII status word (program-counter hex digits, "pass" or "fail") onto an 8N1 UART line for the board's USB-serial bridge.
- Sits directly downstream of the core's tx_word output.
- Sends the four bytes MSB-byte first, optionally followed by CR LF.
- Has an explicit valid/ready handshake plus an optional change-detect mode, so the core's free-running tx_word can be wired straight in.

Parameters:
CLK_FREQ_HZ, 27000000, system clock frequency in Hz.
BAUD, 115200, line rate in bits per second.
APPEND_CRLF, 1, when 1 each word is followed by 0x0D then 0x0A.
CHANGE_DETECT, 1, when 1 an internal request is raised whenever word_in differs from the last word sent; word_valid is then ignored.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
word_in  input  32  word to send; byte 3 (bits 31:24) is sent first.
word_valid  input  1  send request (used only when CHANGE_DETECT=0).
word_ready  output  1  high while idle and able to accept a word.
tx  output  1  UART serial line; idles high.
busy  output  1  high from the cycle after acceptance until the last stop bit completes.

Behaviour:
- CLKS_PER_BIT = CLK_FREQ_HZ / BAUD (integer division). Elaboration fails via $error if CLKS_PER_BIT < 2.
- Reset (rst sampled high at posedge):
  - tx=1, busy=0, word_ready=1, state=IDLE.
  - All counters cleared.
  - last_sent register = 32'h0.
  - Reset mid-frame aborts immediately: tx returns high the next cycle and no partial byte is resumed.
- Request:
  - CHANGE_DETECT=0: req = word_valid.
  - CHANGE_DETECT=1: req = (word_in != last_sent).
  - Acceptance happens at the posedge where state==IDLE and req is high.
  - On acceptance, word_in is latched into a shift buffer and last_sent <= word_in.
  - word_in may change freely after acceptance.
- word_ready is combinational: high exactly when state==IDLE.
- States:
  - IDLE: tx=1. On acceptance -> START with byte_idx=0.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA with bit_idx=0.
  - DATA: tx = current_byte[bit_idx], LSB first, each bit for CLKS_PER_BIT cycles. After bit 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if byte_idx < NBYTES-1: byte_idx++ and -> START, with no idle gap between frames;
    - otherwise -> IDLE.
- NBYTES = 6 if APPEND_CRLF else 4. Byte order: word[31:24], word[23:16], word[15:8], word[7:0], 0x0D, 0x0A.
- Latency: the tx falling edge (start bit) appears on the first cycle after the acceptance edge.
- Whole-word duration is exactly NBYTES*10*CLKS_PER_BIT cycles.
- busy=1 for exactly that duration. word_ready rises the cycle after the final stop bit ends.
- Requests while busy are not queued.
  - CHANGE_DETECT=1: a word that changes several times during a transmission results in only the value present at the next IDLE cycle being sent.
  - CHANGE_DETECT=0: word_valid must be held until word_ready.
- tx is driven from a register; no combinational path from any input to tx.
- The baud counter is the only divider: it reloads at every bit boundary, so there is no fractional-rate accumulation.

Test Plan:
1. CLK_FREQ_HZ=40, BAUD=10 (CLKS_PER_BIT=4), APPEND_CRLF=0, CHANGE_DETECT=0. Pulse word_valid with word_in=32'h70617373 ("pass").
   - tx sequence, each level held 4 cycles: 0, 0,0,0,0,1,1,1,0, 1 (byte 0x70), then frames for 0x61, 0x73, 0x73.
   - busy high for 160 cycles; word_ready high on cycle 161.
2. Same parameters with APPEND_CRLF=1, word_in="fail" (32'h6661696C).
   - Six back-to-back frames 0x66, 0x61, 0x69, 0x6C, 0x0D, 0x0A, with no idle bit between them.
   - busy for 240 cycles.
3. CHANGE_DETECT=1, word_in held at 32'h30303830 after reset.
   - Exactly one transmission occurs, then tx stays 1 indefinitely.
   - Changing word_in to 32'h30303834 triggers exactly one further transmission.
4. CHANGE_DETECT=1: change word_in three times (A, B, C) during a transmission of word X.
   - After X completes, exactly one transmission, of C, follows.
   - A and B never appear on tx.
5. Assert rst during DATA bit 3 of byte 1.
   - tx=1, busy=0, word_ready=1 on the next cycle.
   - Holding word_valid after reset release starts a fresh transmission from byte 0.
6. CHANGE_DETECT=0, word_valid held high continuously with a constant word.
   - Words repeat with exactly one idle cycle (tx=1, word_ready=1) between the last stop bit and the next start bit.
